// File: rtl/mem_arbiter2.sv
// Two-requester arbiter for a shared memory port (fetch vs load/store).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority (two wins).

module mux2_1 #(
  parameter int W = 32
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

module mem_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_one,
  input  logic          req_two,
  input  logic          we_one,
  input  logic          we_two,
  input  logic [AW-1:0] addr_one,
  input  logic [AW-1:0] addr_two,
  input  logic [DW-1:0] wdata_one,
  input  logic [DW-1:0] wdata_two,
  output logic          gnt_one,
  output logic          gnt_two,
  output logic          done_one,
  output logic          done_two,
  output logic [DW-1:0] rdata_out,
  output logic          sel,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        win_two;
  logic        rd_ld;
  logic        tie_two;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when requester two held the port last; reset value lets one win first.
  logic last_two_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_two_q <= 1'b1;
    end else if (state_q == IDLE && (req_one || req_two)) begin
      last_two_q <= win_two;
    end
  end

  assign tie_two = ~last_two_q;
`else
  assign tie_two = 1'b1;
`endif

  always_comb begin
    if (req_one && req_two) begin
      win_two = tie_two;
    end else begin
      win_two = req_two;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    rd_ld   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_one || req_two) begin
          sel_d   = win_two;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rd_ld   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rdata_out <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      if (rd_ld) begin
        rdata_out <= mem_rdata;
      end
    end
  end

  assign sel      = sel_q;
  assign mem_req  = (state_q == BUSY);
  assign gnt_one  = mem_req & ~sel_q;
  assign gnt_two  = mem_req & sel_q;
  assign done_one = (state_q == RESP) & ~sel_q;
  assign done_two = (state_q == RESP) & sel_q;

  mux2_1 #(.W(AW)) u_addr_mux (
    .sel (sel_q),
    .a   (addr_one),
    .b   (addr_two),
    .y   (mem_addr)
  );

  mux2_1 #(.W(DW)) u_wdata_mux (
    .sel (sel_q),
    .a   (wdata_one),
    .b   (wdata_two),
    .y   (mem_wdata)
  );

  mux2_1 #(.W(1)) u_we_mux (
    .sel (sel_q),
    .a   (we_one),
    .b   (we_two),
    .y   (mem_we)
  );

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2.
// Contention expectations follow ARB_ROUND_ROBIN_EN.

module tb_mem_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          req_one, req_two;
  logic          we_one, we_two;
  logic [AW-1:0] addr_one, addr_two;
  logic [DW-1:0] wdata_one, wdata_two;
  logic          gnt_one, gnt_two;
  logic          done_one, done_two;
  logic [DW-1:0] rdata_out;
  logic          sel;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  int n_run;
  int n_fail;

  mem_arbiter2 #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_one   (req_one),
    .req_two   (req_two),
    .we_one    (we_one),
    .we_two    (we_two),
    .addr_one  (addr_one),
    .addr_two  (addr_two),
    .wdata_one (wdata_one),
    .wdata_two (wdata_two),
    .gnt_one   (gnt_one),
    .gnt_two   (gnt_two),
    .done_one  (done_one),
    .done_two  (done_two),
    .rdata_out (rdata_out),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_one   = 1'b0;
    req_two   = 1'b0;
    we_one    = 1'b0;
    we_two    = 1'b0;
    addr_one  = '0;
    addr_two  = '0;
    wdata_one = '0;
    wdata_two = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [3:0] exp_two;
  int         dones;

  initial begin
    n_run  = 0;
    n_fail = 0;
    idle_inputs();
    do_reset();

    // reset state
    check("rst_sel", sel, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_gnt", {gnt_one, gnt_two}, 0);
    check("rst_done", {done_one, done_two}, 0);
    check("rst_rdata", rdata_out, 0);

    // single read from one
    req_one  = 1'b1;
    addr_one = 32'h100;
    addr_two = 32'h999;
    tick();
    check("rd1_mem_req", mem_req, 1);
    check("rd1_addr", mem_addr, 32'h100);
    check("rd1_sel", sel, 0);
    check("rd1_gnt", {gnt_one, gnt_two}, 2'b10);
    check("rd1_we", mem_we, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    check("rd1_done", {done_one, done_two}, 2'b10);
    check("rd1_rdata", rdata_out, 32'hDEADBEEF);
    check("rd1_resp_req", mem_req, 0);
    idle_inputs();
    tick();
    check("rd1_idle_done", {done_one, done_two}, 0);

    // write from two
    req_two   = 1'b1;
    we_two    = 1'b1;
    addr_two  = 32'h40;
    wdata_two = 32'h55;
    tick();
    check("wr2_we", mem_we, 1);
    check("wr2_addr", mem_addr, 32'h40);
    check("wr2_wdata", mem_wdata, 32'h55);
    check("wr2_sel", sel, 1);
    check("wr2_gnt", {gnt_one, gnt_two}, 2'b01);
    tick();
    check("wr2_stall_done", {done_one, done_two}, 0);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0077;
    tick();
    check("wr2_done", {done_one, done_two}, 2'b01);
    check("wr2_rdata", rdata_out, 32'h77);
    idle_inputs();
    tick();

    // spurious mem_ready in IDLE
    mem_ready = 1'b1;
    mem_rdata = 32'h1234;
    tick();
    check("spur_idle_req", mem_req, 0);
    check("spur_idle_done", {done_one, done_two}, 0);
    check("spur_idle_rdata", rdata_out, 32'h77);

    // spurious mem_ready in RESP
    mem_rdata = 32'hA5A5;
    req_one   = 1'b1;
    addr_one  = 32'h8;
    tick();
    tick();
    check("spur_resp_done", {done_one, done_two}, 2'b10);
    check("spur_resp_rdata", rdata_out, 32'hA5A5);
    req_one   = 1'b0;
    mem_rdata = 32'hFFFF;
    tick();
    check("spur_resp_idle_req", mem_req, 0);
    check("spur_resp_idle_done", {done_one, done_two}, 0);
    check("spur_resp_hold", rdata_out, 32'hA5A5);
    idle_inputs();
    tick();

    // memory stall for 10 cycles
    req_one  = 1'b1;
    addr_one = 32'h200;
    dones    = 0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_req", mem_req, 1);
      check("stall_gnt", {gnt_one, gnt_two}, 2'b10);
      check("stall_addr", mem_addr, 32'h200);
      if (done_one || done_two) dones++;
      tick();
    end
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE;
    tick();
    if (done_one || done_two) dones++;
    check("stall_done1", done_one, 1);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_one || done_two) dones++;
    end
    check("stall_done_cnt", dones, 1);
    check("stall_rdata", rdata_out, 32'hCAFE);

    // req dropped during BUSY still completes
    req_two  = 1'b1;
    addr_two = 32'h44;
    tick();
    check("drop_busy", mem_req, 1);
    req_two = 1'b0;
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'h9;
    tick();
    check("drop_done", {done_one, done_two}, 2'b01);
    idle_inputs();
    tick();

    // reset two cycles into a stall
    req_two  = 1'b1;
    addr_two = 32'h300;
    tick();
    tick();
    tick();
    check("rst_mid_busy", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_gnt", {gnt_one, gnt_two}, 0);
    check("arst_sel", sel, 0);
    check("arst_rdata", rdata_out, 0);
    check("arst_done", {done_one, done_two}, 0);
    idle_inputs();
    tick();
    check("arst_hold_done", {done_one, done_two}, 0);
    rst = 1'b0;
    tick();
    check("post_rst_done", {done_one, done_two}, 0);
    req_one  = 1'b1;
    addr_one = 32'h500;
    tick();
    check("post_rst_addr", mem_addr, 32'h500);
    mem_ready = 1'b1;
    mem_rdata = 32'h42;
    tick();
    check("post_rst_done1", {done_one, done_two}, 2'b10);
    check("post_rst_rdata", rdata_out, 32'h42);
    idle_inputs();
    tick();

    // contention from a fresh reset
    do_reset();
`ifdef ARB_ROUND_ROBIN_EN
    exp_two = 4'b1010;
`else
    exp_two = 4'b1111;
`endif
    req_one   = 1'b1;
    req_two   = 1'b1;
    addr_one  = 32'h10;
    addr_two  = 32'h20;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cont_sel", sel, exp_two[i]);
      check("cont_addr", mem_addr, exp_two[i] ? 32'h20 : 32'h10);
      tick();
      check("cont_done", {done_one, done_two},
            exp_two[i] ? 2'b01 : 2'b10);
      tick();
    end
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1);
  end

endmodule
